// File: rtl/board_display_if.sv
// Signal bundle between the VGA/game logic and the board display back-end.
// The master side presents pixel coordinates, board state and score digits;
// the slave side (the display unit) returns pixel colour, the 7-segment drive
// and the two slow timebases.
interface board_display_if;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [17:0] memory;
  logic        is_end;
  logic [15:0] digits;
  logic [3:0]  render_r;
  logic [3:0]  render_g;
  logic [3:0]  render_b;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        blink;
  logic        sec_clk;

  modport master (
    output x, y, memory, is_end, digits,
    input  render_r, render_g, render_b, seg, an, blink, sec_clk
  );

  modport slave (
    input  x, y, memory, is_end, digits,
    output render_r, render_g, render_b, seg, an, blink, sec_clk
  );
endinterface

// File: rtl/board_display_unit.sv
// Display back-end for pyramid tic-tac-toe: three clock dividers (digit scan,
// cursor blink, 1 Hz timebase), a 4-digit common-anode 7-segment multiplexer
// and a registered per-pixel renderer for the 9-cell pyramid board.
module board_display_unit #(
  parameter int SCAN_DIV  = 208334,
  parameter int BLINK_DIV = 12500000,
  parameter int SEC_DIV   = 50000000,
  parameter int DIV_W     = 26
) (
  input  logic           clock,
  input  logic           reset,
  board_display_if.slave bus
);

  localparam logic [DIV_W-1:0] SCAN_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLINK_LAST = DIV_W'(BLINK_DIV - 1);
  localparam logic [DIV_W-1:0] SEC_LAST   = DIV_W'(SEC_DIV - 1);
  localparam logic [DIV_W-1:0] CNT_ONE    = DIV_W'(1);

  // Active-low gfedcba pattern for one BCD digit; codes 10-15 are blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Left edge of grid column c (five columns, 120 px pitch).
  function automatic logic [9:0] x_org(input logic [2:0] c);
    logic [9:0] o;
    case (c)
      3'd0:    o = 10'd10;
      3'd1:    o = 10'd130;
      3'd2:    o = 10'd250;
      3'd3:    o = 10'd370;
      3'd4:    o = 10'd490;
      default: o = 10'd0;
    endcase
    return o;
  endfunction

  // Top edge of grid row r (three rows, 154 px pitch).
  function automatic logic [8:0] y_org(input logic [1:0] r);
    logic [8:0] o;
    case (r)
      2'd0:    o = 9'd10;
      2'd1:    o = 9'd164;
      2'd2:    o = 9'd318;
      default: o = 9'd0;
    endcase
    return o;
  endfunction

  // Divider / scan state
  logic [DIV_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DIV_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [DIV_W-1:0] sec_cnt_q, sec_cnt_d;
  logic             scan_tog_q, scan_tog_d;
  logic             blink_q, blink_d;
  logic             sec_q, sec_d;
  logic [1:0]       scan_idx_q, scan_idx_d;

  // Render state
  logic [3:0] r_q, r_d, g_q, g_d, b_q, b_d;

  // Render intermediates
  logic       col_hit_s, row_hit_s, cell_hit_s;
  logic [2:0] col_s;
  logic [1:0] row_s;
  logic [3:0] cell_s;
  logic [6:0] u_s, v_s, a_s, b_s;
  logic [9:0] dx_s;
  logic [8:0] dy_s;
  logic       outline_s, glyph_ok_s, on_x_s, on_o_s;
  logic [6:0] dab_s, ra_s, rb_s;
  logic [7:0] sum_s, dsum_s;
  logic [12:0] rad_s;
  logic [6:0] seg_s;
  logic [3:0] an_s;

  // Register update for dividers, scan index and render colour.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      sec_cnt_q   <= '0;
      scan_tog_q  <= 1'b1;
      blink_q     <= 1'b1;
      sec_q       <= 1'b1;
      scan_idx_q  <= 2'd0;
      r_q         <= 4'h0;
      g_q         <= 4'h0;
      b_q         <= 4'h0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      sec_cnt_q   <= sec_cnt_d;
      scan_tog_q  <= scan_tog_d;
      blink_q     <= blink_d;
      sec_q       <= sec_d;
      scan_idx_q  <= scan_idx_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
    end
  end

  // Divider next-state: wrap at DIV-1 and toggle; scan index steps on the
  // low-to-high transition of the scan toggle.
  always_comb begin
    scan_cnt_d  = scan_cnt_q + CNT_ONE;
    scan_tog_d  = scan_tog_q;
    scan_idx_d  = scan_idx_q;
    blink_cnt_d = blink_cnt_q + CNT_ONE;
    blink_d     = blink_q;
    sec_cnt_d   = sec_cnt_q + CNT_ONE;
    sec_d       = sec_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_tog_d = ~scan_tog_q;
      if (!scan_tog_q) scan_idx_d = scan_idx_q + 2'd1;
      else             scan_idx_d = scan_idx_q;
    end else begin
      scan_cnt_d = scan_cnt_q + CNT_ONE;
    end
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + CNT_ONE;
    end
    if (sec_cnt_q == SEC_LAST) begin
      sec_cnt_d = '0;
      sec_d     = ~sec_q;
    end else begin
      sec_cnt_d = sec_cnt_q + CNT_ONE;
    end
  end

  // Digit multiplexer: one-hot-low anode and the decoded selected nibble.
  always_comb begin
    an_s  = 4'b1110;
    seg_s = 7'b1111111;
    case (scan_idx_q)
      2'd0:    begin an_s = 4'b1110; seg_s = seg_decode(bus.digits[3:0]);   end
      2'd1:    begin an_s = 4'b1101; seg_s = seg_decode(bus.digits[7:4]);   end
      2'd2:    begin an_s = 4'b1011; seg_s = seg_decode(bus.digits[11:8]);  end
      2'd3:    begin an_s = 4'b0111; seg_s = seg_decode(bus.digits[15:12]); end
      default: begin an_s = 4'b1110; seg_s = 7'b1111111;                   end
    endcase
  end

  // Pixel renderer: locate grid slot, map to cell, then glyph/outline colour.
  // Offsets use unsigned wrap so a pixel left of / above an origin never hits.
  always_comb begin
    col_hit_s = 1'b0;
    row_hit_s = 1'b0;
    col_s     = 3'd0;
    row_s     = 2'd0;
    u_s       = 7'd0;
    v_s       = 7'd0;
    dx_s      = 10'd0;
    dy_s      = 9'd0;
    for (int c = 0; c < 5; c++) begin
      dx_s = bus.x - x_org(3'(c));
      if (dx_s <= 10'd102) begin
        col_hit_s = 1'b1;
        col_s     = 3'(c);
        u_s       = dx_s[6:0];
      end else begin
        col_hit_s = col_hit_s;
      end
    end
    for (int r = 0; r < 3; r++) begin
      dy_s = bus.y - y_org(2'(r));
      if (dy_s <= 9'd102) begin
        row_hit_s = 1'b1;
        row_s     = 2'(r);
        v_s       = dy_s[6:0];
      end else begin
        row_hit_s = row_hit_s;
      end
    end

    // Pyramid layout: one cell on top, three in the middle, five at the base.
    cell_hit_s = 1'b0;
    cell_s     = 4'd0;
    case (row_s)
      2'd0: begin
        cell_hit_s = (col_s == 3'd2);
        cell_s     = 4'd0;
      end
      2'd1: begin
        cell_hit_s = (col_s >= 3'd1) && (col_s <= 3'd3);
        cell_s     = {1'b0, col_s};
      end
      2'd2: begin
        cell_hit_s = 1'b1;
        cell_s     = 4'd4 + {1'b0, col_s};
      end
      default: begin
        cell_hit_s = 1'b0;
        cell_s     = 4'd0;
      end
    endcase
    cell_hit_s = cell_hit_s && col_hit_s && row_hit_s &&
                 (bus.x < 10'd640) && (bus.y < 9'd480);

    outline_s  = (u_s < 7'd3) || (u_s > 7'd99) || (v_s < 7'd3) || (v_s > 7'd99);
    glyph_ok_s = (u_s >= 7'd8) && (u_s <= 7'd94) && (v_s >= 7'd8) && (v_s <= 7'd94);
    a_s        = u_s - 7'd8;
    b_s        = v_s - 7'd8;

    // X: two diagonal bands of half-width 6.
    dab_s  = (a_s >= b_s) ? (a_s - b_s) : (b_s - a_s);
    sum_s  = {1'b0, a_s} + {1'b0, b_s};
    dsum_s = (sum_s >= 8'd86) ? (sum_s - 8'd86) : (8'd86 - sum_s);
    on_x_s = (dab_s <= 7'd6) || (dsum_s <= 8'd6);

    // O: ring between radius 30 and 40 around (43, 43).
    ra_s   = (a_s >= 7'd43) ? (a_s - 7'd43) : (7'd43 - a_s);
    rb_s   = (b_s >= 7'd43) ? (b_s - 7'd43) : (7'd43 - b_s);
    rad_s  = ({6'd0, ra_s} * {6'd0, ra_s}) + ({6'd0, rb_s} * {6'd0, rb_s});
    on_o_s = (rad_s >= 13'd900) && (rad_s <= 13'd1600);

    r_d = 4'h0;
    g_d = 4'h0;
    b_d = 4'h0;
    if (cell_hit_s) begin
      if (glyph_ok_s && bus.memory[9 + cell_s] && !bus.memory[cell_s] && on_x_s) begin
        r_d = 4'hF;
      end else if (glyph_ok_s && bus.memory[9 + cell_s] && bus.memory[cell_s] && on_o_s) begin
        b_d = 4'hF;
      end else if (outline_s) begin
        r_d = 4'h8;
        g_d = 4'h8;
        b_d = 4'h8;
      end else begin
        r_d = 4'h0;
      end
    end else begin
      r_d = 4'h0;
    end

    // Game over: dim the board under the result overlay.
    if (bus.is_end) begin
      r_d = (r_d != 4'h0) ? 4'h7 : 4'h0;
      g_d = (g_d != 4'h0) ? 4'h7 : 4'h0;
      b_d = (b_d != 4'h0) ? 4'h7 : 4'h0;
    end else begin
      r_d = r_d;
    end
  end

  assign bus.render_r = r_q;
  assign bus.render_g = g_q;
  assign bus.render_b = b_q;
  assign bus.seg      = seg_s;
  assign bus.an       = an_s;
  assign bus.blink    = blink_q;
  assign bus.sec_clk  = sec_q;

endmodule

// File: tb/tb_board_display_unit.sv
// Directed bench for board_display_unit with short dividers
// (scan 2, blink 4, sec 4) so the timebases are observable in a few clocks.
module tb_board_display_unit;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  board_display_if bus ();

  board_display_unit #(
    .SCAN_DIV (2),
    .BLINK_DIV(4),
    .SEC_DIV  (4),
    .DIV_W    (26)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 7-segment table (active low, gfedcba).
  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0: p = 7'b1000000;
      4'd1: p = 7'b1111001;
      4'd2: p = 7'b0100100;
      4'd3: p = 7'b0110000;
      4'd4: p = 7'b0011001;
      4'd5: p = 7'b0010010;
      4'd6: p = 7'b0000010;
      4'd7: p = 7'b1111000;
      4'd8: p = 7'b0000000;
      4'd9: p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a pixel, wait one clock, compare the registered colour {r,g,b}.
  task automatic pix(input string tag, input logic [17:0] mem, input logic end_g,
                     input logic [9:0] px, input logic [8:0] py, input logic [11:0] exp);
    bus.memory = mem;
    bus.is_end = end_g;
    bus.x      = px;
    bus.y      = py;
    @(negedge clk);
    chk(tag, {20'd0, bus.render_r, bus.render_g, bus.render_b}, {20'd0, exp});
  endtask

  initial begin
    logic [15:0] dig;
    int          idx;
    checks = 0;
    errors = 0;
    rst        = 1'b1;
    bus.x      = 10'd0;
    bus.y      = 9'd0;
    bus.memory = 18'd0;
    bus.is_end = 1'b0;
    bus.digits = 16'h1209;
    dig        = 16'h1209;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_an",    {28'd0, bus.an}, 32'h0000000E);
    chk("rst_seg",   {25'd0, bus.seg}, {25'd0, 7'b0010000});
    chk("rst_blink", {31'd0, bus.blink}, 32'd1);
    chk("rst_sec",   {31'd0, bus.sec_clk}, 32'd1);
    chk("rst_rgb",   {20'd0, bus.render_r, bus.render_g, bus.render_b}, 32'd0);

    // Run six clocks: blink has toggled once, scan index has advanced to 1
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_blink", {31'd0, bus.blink}, 32'd0);
    chk("mid_an",    {28'd0, bus.an}, {28'd0, 4'b1101});

    // Asynchronous reset mid-count: outputs return at once, no clock edge
    rst = 1'b1;
    #1;
    chk("async_blink", {31'd0, bus.blink}, 32'd1);
    chk("async_sec",   {31'd0, bus.sec_clk}, 32'd1);
    chk("async_an",    {28'd0, bus.an}, {28'd0, 4'b1110});
    @(negedge clk);
    rst = 1'b0;

    // Timebases and digit scan after release: blink/sec toggle every 4
    // clocks, scan index steps every 4 clocks (scan toggle period 4).
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      idx = (k / 4) % 4;
      chk($sformatf("blink_k%0d", k), {31'd0, bus.blink}, {31'd0, ((k / 4) % 2) == 0});
      chk($sformatf("sec_k%0d", k),   {31'd0, bus.sec_clk}, {31'd0, ((k / 4) % 2) == 0});
      chk($sformatf("an_k%0d", k),    {28'd0, bus.an}, {28'd0, ~(4'b0001 << idx)});
      chk($sformatf("seg_k%0d", k),   {25'd0, bus.seg}, {25'd0, ref_seg(4'((dig >> (4 * idx)) & 16'h000F))});
    end

    // Cell 0 (slot 2,0: origin 250,10) holding X
    pix("x_main_diag",  18'h00200, 1'b0, 10'd301, 9'd61,  12'hF00);
    pix("x_diag2",      18'h00200, 1'b0, 10'd291, 9'd51,  12'hF00);
    pix("x_band_edge6", 18'h00200, 1'b0, 10'd297, 9'd51,  12'hF00);
    pix("x_band_out7",  18'h00200, 1'b0, 10'd298, 9'd51,  12'h000);
    pix("x_interior",   18'h00200, 1'b0, 10'd300, 9'd40,  12'h000);
    pix("c0_outline",   18'h00200, 1'b0, 10'd250, 9'd11,  12'h888);

    // Unoccupied cell 0: outline only, sign bit ignored
    pix("unocc_glyph",  18'h00001, 1'b0, 10'd291, 9'd51,  12'h000);
    pix("unocc_outl",   18'h00001, 1'b0, 10'd250, 9'd11,  12'h888);

    // Cell 4 (slot 0,2: origin 10,318) holding O
    pix("o_centre",     18'h02010, 1'b0, 10'd61,  9'd351, 12'h000);
    pix("o_ring",       18'h02010, 1'b0, 10'd96,  9'd351, 12'h00F);
    pix("o_r2_900",     18'h02010, 1'b0, 10'd91,  9'd369, 12'h00F);
    pix("o_r2_841",     18'h02010, 1'b0, 10'd90,  9'd369, 12'h000);
    pix("o_r2_1600",    18'h02010, 1'b0, 10'd101, 9'd369, 12'h00F);
    pix("o_r2_1681",    18'h02010, 1'b0, 10'd102, 9'd369, 12'h000);

    // Game over dimming
    pix("end_o_ring",   18'h02010, 1'b1, 10'd96,  9'd351, 12'h007);
    pix("end_outline",  18'h02010, 1'b1, 10'd11,  9'd330, 12'h777);
    pix("end_x",        18'h00200, 1'b1, 10'd301, 9'd61,  12'h700);

    // Other cells, non-cell slots and off-screen pixels
    pix("c8_x_centre",  18'h20000, 1'b0, 10'd541, 9'd369, 12'hF00);
    pix("c2_outline",   18'h00000, 1'b0, 10'd352, 9'd200, 12'h888);
    pix("noncell_slot", 18'h3FFFF, 1'b0, 10'd40,  9'd40,  12'h000);
    pix("gap_pixel",    18'h3FFFF, 1'b0, 10'd120, 9'd351, 12'h000);
    pix("offscreen_x",  18'h3FFFF, 1'b0, 10'd700, 9'd351, 12'h000);

    // Blank digit code at scan index 0
    bus.digits = 16'h000C;
    rst = 1'b1;
    #1;
    chk("blank_an",  {28'd0, bus.an}, {28'd0, 4'b1110});
    chk("blank_seg", {25'd0, bus.seg}, {25'd0, 7'b1111111});
    chk("rst_rgb2",  {20'd0, bus.render_r, bus.render_g, bus.render_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
